mathbox_sequencer: RTL and testbench
====================================

# mathbox_sequencer

Microprogram sequencer for the aux-PCB math box: it steps a 4-slice (16-bit) cascade of 2901-style ALU slices through microcode held in an external synchronous ROM. A host strobe supplies a start address and a 16-bit operand. The sequencer fetches microwords, drives the slice control inputs, branches on the cascade status flags, captures results, and signals completion. It sits between the host/CPU command decode and the slice cascade, and is the only block that drives the slice I/address/carry lines.

## Interface
Parameters:
- `UADDR_W`, 8, microcode address width
- `MAX_STEPS`, 255, executed-microword limit before abort

Ports:
- `cp`  in  1  clock, shared with the slices
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  host command strobe
- `startAddr`  in  UADDR_W  first microword address
- `operand`  in  16  host data, latched on accepted `start`
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky abort flag, cleared by next accepted `start`
- `result`  out  16  last captured cascade Y
- `uAddr`  out  UADDR_W  ROM address
- `uWord`  in  32  ROM data, valid one cycle after `uAddr`
- `aluI`  out  9  slice I[8:0]
- `aAddr`, `bAddr`  out  4 each  slice register addresses
- `cN`  out  1  carry into least-significant slice
- `dOut`  out  16  slice D inputs
- `yOeBar`  out  1  slice output enable, active-low
- `y`  in  16  cascade Y
- `fEq0`, `f3`, `ovf`, `cNplus4`  in  1 each  cascade status (most-significant slice)

## Operation
Microword fields, MSB→LSB:
- `i`[31:23]
- `a`[22:19]
- `b`[18:15]
- `cn`[14]
- `dEn`[13]
- `yLatch`[12]
- `seqOp`[11:10]: CONT=0, JUMP=1, JCOND=2, HALT=3
- `condSel`[9:8]: fEq0, f3, ovf, cNplus4
- `target`[7:0]

States:
- IDLE
  - `aluI` = 9'h040 (I[8:6]=001: no Q or RAM write). `yOeBar`=1. `cN`=0. `dOut`=0.
  - On `start`: latch `operand`, `uPC`←`startAddr`, clear `err` and step count, go FETCH.
- FETCH
  - `uAddr`=`uPC`. Slice outputs held at NOP values.
  - Next edge: `uIR`←`uWord`, go EXEC.
- EXEC
  - Drive `aluI`=`uIR.i`, `aAddr`/`bAddr`, `cN`=`uIR.cn`, `dOut`=`dEn` ? latched operand : 0, `yOeBar`=0.
  - At the end-of-cycle edge:
    - If `yLatch`: `result`←`y`.
    - Next `uPC`:
      - CONT: `uPC`+1, wrapping modulo 2^UADDR_W.
      - JUMP: `target`.
      - JCOND: `target` if the selected flag=1, else `uPC`+1.
      - HALT: go DONE.
    - Step count +1. If it reaches MAX_STEPS and the op is not HALT: set `err`, go DONE.
    - Otherwise go FETCH.
- DONE: `done`=1 for one cycle, slices at NOP, return to IDLE.

Rules:
- `start` while `busy` is ignored; operand and `uPC` are untouched.
- `start` in the DONE cycle is ignored.
- `start` in IDLE with `reset` high is ignored.
- A HALT microword still executes its slice operation and `yLatch`.

## Timing
- Two cycles per microword (FETCH+EXEC). Latency from `start` to `done` = 2·N+1 cycles for N executed microwords.
- Flags are sampled combinationally at the EXEC closing edge, the same edge on which the slices commit Q/RAM.
- `busy` rises the cycle after `start` and falls with the cycle after `done`.
- Reset values:
  - IDLE, `uPC`=0, `uIR`=0, step count 0.
  - `busy`=0, `done`=0, `err`=0, `result`=0, `uAddr`=0.
  - `aluI`=9'h040, `aAddr`=`bAddr`=0, `cN`=0, `dOut`=0, `yOeBar`=1.
- Reset mid-program: next edge forces the reset state, no `done` pulse. Slice register contents are not cleared.

## Structure
- Package `mathboxPkg`:
  - microword struct typedef
  - `seqOp`/`condSel` enums
  - state enum
  - NOP constant 9'h040
- Sub-module `condSelect`: 4:1 flag mux feeding the JCOND decision.
- Next-address logic and step counter stay in the top module.

## Test plan
- Reset, then idle 5 cycles → `aluI`=9'h040, `yOeBar`=1, `busy`=0, `uAddr`=0.
- `start` @0x10, ROM[0x10]=CONT, ROM[0x11]=HALT with `yLatch`, `y`=16'h1234 → `done` 5 cycles after `start`, `result`=16'h1234.
- JCOND on fEq0: `fEq0`=1 → `uAddr` next = `target` 0x40; `fEq0`=0 → `uAddr`=`uPC`+1.
- CONT at 0xFF → next `uAddr`=0x00.
- JUMP-to-self loop with MAX_STEPS=4 → `err`=1 and `done` after 4 EXECs. The next `start` clears `err`.
- `start` pulsed while `busy` → `operand`/`uPC` unchanged. Reset asserted mid-EXEC → state IDLE, `done` never pulses.

Source files
------------

// File: rtl/mathbox_sequencer_pkg.sv
// Shared types and constants for the math-box microprogram sequencer.
package mathboxPkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned UWORD_W    = 32;
  localparam int unsigned ALU_I_W    = 9;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned TARGET_W   = 8;

  // I[8:6]=001 selects no Q/RAM write, so the slices hold their state.
  localparam logic [ALU_I_W-1:0] ALU_NOP = 9'h040;

  typedef enum logic [1:0] {
    SEQ_CONT  = 2'd0,
    SEQ_JUMP  = 2'd1,
    SEQ_JCOND = 2'd2,
    SEQ_HALT  = 2'd3
  } seq_op_e;

  typedef enum logic [1:0] {
    COND_FEQ0    = 2'd0,
    COND_F3      = 2'd1,
    COND_OVF     = 2'd2,
    COND_CNPLUS4 = 2'd3
  } cond_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ALU_I_W-1:0]    i;
    logic [REG_ADDR_W-1:0] a;
    logic [REG_ADDR_W-1:0] b;
    logic                  cn;
    logic                  d_en;
    logic                  y_latch;
    seq_op_e               seq_op;
    cond_sel_e             cond_sel;
    logic [TARGET_W-1:0]   target;
  } uword_t;

  // Sequencing half of the instruction register; the slice half lives in the output registers.
  typedef struct packed {
    logic                y_latch;
    seq_op_e             seq_op;
    cond_sel_e           cond_sel;
    logic [TARGET_W-1:0] target;
  } seq_ctl_t;

  function automatic seq_ctl_t seq_ctl(input uword_t w);
    seq_ctl_t s;
    s.y_latch  = w.y_latch;
    s.seq_op   = w.seq_op;
    s.cond_sel = w.cond_sel;
    s.target   = w.target;
    return s;
  endfunction

endpackage

// File: rtl/mathbox_sequencer_if.sv
// Host command, microcode ROM and slice-cascade signals of the sequencer.
interface mathbox_sequencer_if
  import mathboxPkg::*;
#(
  parameter int unsigned UADDR_W = 8
);

  logic                  start;
  logic [UADDR_W-1:0]    startAddr;
  logic [DATA_W-1:0]     operand;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_W-1:0]     result;
  logic [UADDR_W-1:0]    uAddr;
  logic [UWORD_W-1:0]    uWord;
  logic [ALU_I_W-1:0]    aluI;
  logic [REG_ADDR_W-1:0] aAddr;
  logic [REG_ADDR_W-1:0] bAddr;
  logic                  cN;
  logic [DATA_W-1:0]     dOut;
  logic                  yOeBar;
  logic [DATA_W-1:0]     y;
  logic                  fEq0;
  logic                  f3;
  logic                  ovf;
  logic                  cNplus4;

  modport master (
    output start, startAddr, operand, uWord, y, fEq0, f3, ovf, cNplus4,
    input  busy, done, err, result, uAddr, aluI, aAddr, bAddr, cN, dOut, yOeBar
  );

  modport slave (
    input  start, startAddr, operand, uWord, y, fEq0, f3, ovf, cNplus4,
    output busy, done, err, result, uAddr, aluI, aAddr, bAddr, cN, dOut, yOeBar
  );

endinterface

// File: rtl/mathbox_sequencer_cond_select.sv
// 4:1 cascade status mux feeding the conditional-branch decision.
module condSelect
  import mathboxPkg::*;
(
  input  cond_sel_e sel,
  input  logic      fEq0,
  input  logic      f3,
  input  logic      ovf,
  input  logic      cNplus4,
  output logic      hit_c
);

  always_comb begin
    hit_c = 1'b0;
    case (sel)
      COND_FEQ0:    hit_c = fEq0;
      COND_F3:      hit_c = f3;
      COND_OVF:     hit_c = ovf;
      COND_CNPLUS4: hit_c = cNplus4;
      default:      hit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mathbox_sequencer.sv
// Microprogram sequencer driving a 4-slice 2901 cascade from an external microcode ROM.
// Each microword takes a FETCH cycle and an EXEC cycle; HALT or the step limit ends the program.
module mathbox_sequencer
  import mathboxPkg::*;
#(
  parameter int unsigned UADDR_W   = 8,
  parameter int unsigned MAX_STEPS = 255
) (
  input logic          cp,
  input logic          reset,
  mathbox_sequencer_if.slave bus
);

  localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

  state_e                state;
  logic [UADDR_W-1:0]    upc;
  seq_ctl_t              uir;
  logic [STEP_W-1:0]     steps;
  logic [DATA_W-1:0]     opnd;

  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_W-1:0]     result;
  logic [ALU_I_W-1:0]    alu_i;
  logic [REG_ADDR_W-1:0] a_addr;
  logic [REG_ADDR_W-1:0] b_addr;
  logic                  cn;
  logic [DATA_W-1:0]     d_out;
  logic                  y_oe_bar;

  uword_t                fetched_c;
  logic                  cond_hit_c;
  logic [UADDR_W-1:0]    upc_next_c;
  logic [STEP_W-1:0]     steps_inc_c;
  logic                  limit_hit_c;

  assign fetched_c = uword_t'(bus.uWord);

  condSelect u_cond (
    .sel     (uir.cond_sel),
    .fEq0    (bus.fEq0),
    .f3      (bus.f3),
    .ovf     (bus.ovf),
    .cNplus4 (bus.cNplus4),
    .hit_c   (cond_hit_c)
  );

  // Next microword address and step accounting for the EXEC closing edge.
  always_comb begin
    upc_next_c  = upc + UADDR_W'(1);
    steps_inc_c = steps + STEP_W'(1);
    limit_hit_c = (steps_inc_c == STEP_W'(MAX_STEPS));
    case (uir.seq_op)
      SEQ_JUMP:  upc_next_c = UADDR_W'(uir.target);
      SEQ_JCOND: if (cond_hit_c) upc_next_c = UADDR_W'(uir.target);
      default:   ;
    endcase
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      state    <= ST_IDLE;
      upc      <= '0;
      uir      <= seq_ctl_t'(0);
      steps    <= '0;
      opnd     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      alu_i    <= ALU_NOP;
      a_addr   <= '0;
      b_addr   <= '0;
      cn       <= 1'b0;
      d_out    <= '0;
      y_oe_bar <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            opnd  <= bus.operand;
            upc   <= bus.startAddr;
            err   <= 1'b0;
            steps <= '0;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end
        end

        // Slice controls go live together with the latched microword.
        ST_FETCH: begin
          uir      <= seq_ctl(fetched_c);
          alu_i    <= fetched_c.i;
          a_addr   <= fetched_c.a;
          b_addr   <= fetched_c.b;
          cn       <= fetched_c.cn;
          d_out    <= fetched_c.d_en ? opnd : '0;
          y_oe_bar <= 1'b0;
          state    <= ST_EXEC;
        end

        ST_EXEC: begin
          if (uir.y_latch) result <= bus.y;
          steps    <= steps_inc_c;
          alu_i    <= ALU_NOP;
          a_addr   <= '0;
          b_addr   <= '0;
          cn       <= 1'b0;
          d_out    <= '0;
          y_oe_bar <= 1'b1;
          if (uir.seq_op == SEQ_HALT) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (limit_hit_c) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            upc   <= upc_next_c;
            state <= ST_FETCH;
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.err    = err;
  assign bus.result = result;
  assign bus.uAddr  = upc;
  assign bus.aluI   = alu_i;
  assign bus.aAddr  = a_addr;
  assign bus.bAddr  = b_addr;
  assign bus.cN     = cn;
  assign bus.dOut   = d_out;
  assign bus.yOeBar = y_oe_bar;

endmodule

// File: tb/tb_mathbox_sequencer.sv
// Bench for mathbox_sequencer: directed programs plus random ROM contents against a microword-level model.
module tb_mathbox_sequencer;

  localparam int unsigned MAXS = 4;
  localparam logic [8:0]  NOP  = 9'h040;

  logic        cp = 1'b0;
  logic        reset;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rom [256];
  logic [15:0] m_result;
  logic        m_err;

  mathbox_sequencer_if #(.UADDR_W(8)) bus ();

  assign bus.uWord = rom[bus.uAddr];

  mathbox_sequencer #(.UADDR_W(8), .MAX_STEPS(MAXS)) dut (
    .cp    (cp),
    .reset (reset),
    .bus   (bus)
  );

  always #5 cp = ~cp;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  // Random slice fields with the given sequencing fields.
  function automatic logic [31:0] mk(input logic [1:0] op, input logic [1:0] cs,
                                     input logic [7:0] tgt, input logic yl, input logic den);
    logic [31:0] w;
    w       = $urandom;
    w[13]   = den;
    w[12]   = yl;
    w[11:10] = op;
    w[9:8]  = cs;
    w[7:0]  = tgt;
    return w;
  endfunction

  // Runs one program from start strobe through the first IDLE cycle, checking every cycle.
  task automatic run_prog(input logic [7:0] saddr, input logic [15:0] opd,
                          input bit fix_flags, input logic [3:0] flg,
                          input bit fix_y, input logic [15:0] yv, input bit poke);
    int          pc;
    int          steps;
    bit          fin;
    logic [31:0] w;
    logic [3:0]  fl;
    logic [15:0] exp_d;
    bus.start = 1'b1; bus.startAddr = saddr; bus.operand = opd;
    tick();
    bus.start = 1'b0;
    pc = int'(saddr); steps = 0; fin = 1'b0; m_err = 1'b0;
    while (!fin) begin
      checks++;
      if ({bus.busy, bus.done, bus.uAddr, bus.aluI, bus.cN, bus.dOut, bus.yOeBar} !==
          {1'b1, 1'b0, 8'(pc), NOP, 1'b0, 16'h0, 1'b1}) begin
        failures++;
        $display("FAIL fetch pc=%02h got busy=%b done=%b uAddr=%02h aluI=%03h cN=%b dOut=%04h oe=%b exp uAddr=%02h",
                 pc, bus.busy, bus.done, bus.uAddr, bus.aluI, bus.cN, bus.dOut, bus.yOeBar, 8'(pc));
      end
      tick();
      w     = rom[pc];
      exp_d = w[13] ? opd : 16'h0;
      checks++;
      if ({bus.busy, bus.done, bus.aluI, bus.aAddr, bus.bAddr, bus.cN, bus.dOut, bus.yOeBar} !==
          {1'b1, 1'b0, w[31:23], w[22:19], w[18:15], w[14], exp_d, 1'b0}) begin
        failures++;
        $display("FAIL exec pc=%02h got aluI=%03h a=%h b=%h cN=%b dOut=%04h oe=%b done=%b exp aluI=%03h a=%h b=%h cN=%b dOut=%04h",
                 pc, bus.aluI, bus.aAddr, bus.bAddr, bus.cN, bus.dOut, bus.yOeBar, bus.done,
                 w[31:23], w[22:19], w[18:15], w[14], exp_d);
      end
      fl = fix_flags ? flg : 4'($urandom);
      {bus.cNplus4, bus.ovf, bus.f3, bus.fEq0} = fl;
      bus.y = fix_y ? yv : 16'($urandom);
      if (poke && steps == 0) begin
        bus.start = 1'b1; bus.startAddr = ~saddr; bus.operand = ~opd;
      end
      steps++;
      if (w[12]) m_result = bus.y;
      if (w[11:10] == 2'd3) fin = 1'b1;
      else if (steps == MAXS) begin fin = 1'b1; m_err = 1'b1; end
      else if (w[11:10] == 2'd1 || (w[11:10] == 2'd2 && fl[w[9:8]])) pc = int'(w[7:0]);
      else pc = (pc + 1) % 256;
      tick();
      bus.start = 1'b0;
    end
    checks++;
    if ({bus.done, bus.busy, bus.err, bus.result, bus.aluI, bus.yOeBar, bus.dOut} !==
        {1'b1, 1'b1, m_err, m_result, NOP, 1'b1, 16'h0}) begin
      failures++;
      $display("FAIL done_cycle got done=%b busy=%b err=%b result=%04h aluI=%03h oe=%b exp err=%b result=%04h",
               bus.done, bus.busy, bus.err, bus.result, bus.aluI, bus.yOeBar, m_err, m_result);
    end
    if (poke) begin bus.start = 1'b1; bus.startAddr = saddr + 8'd1; end
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.done, bus.busy, bus.err, bus.result} !== {1'b0, 1'b0, m_err, m_result}) begin
      failures++;
      $display("FAIL idle_after got done=%b busy=%b err=%b result=%04h exp err=%b result=%04h",
               bus.done, bus.busy, bus.err, bus.result, m_err, m_result);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({bus.busy, bus.done, bus.err, bus.result, bus.uAddr, bus.aluI, bus.aAddr, bus.bAddr,
           bus.cN, bus.dOut, bus.yOeBar} !==
          {1'b0, 1'b0, 1'b0, 16'h0, 8'h00, NOP, 4'h0, 4'h0, 1'b0, 16'h0, 1'b1}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got busy=%b done=%b err=%b result=%04h uAddr=%02h aluI=%03h oe=%b",
                 c, bus.busy, bus.done, bus.err, bus.result, bus.uAddr, bus.aluI, bus.yOeBar);
      end
    end
  endtask

  task automatic test_cont_halt();
    rom[8'h10] = mk(2'd0, 2'd0, 8'h00, 1'b0, 1'b1);
    rom[8'h11] = mk(2'd3, 2'd0, 8'h00, 1'b1, 1'b0);
    run_prog(8'h10, 16'hBEEF, 1'b0, 4'h0, 1'b1, 16'h1234, 1'b0);
    checks++;
    if (bus.result !== 16'h1234) begin
      failures++;
      $display("FAIL cont_halt_result got=%04h exp=1234", bus.result);
    end
  endtask

  task automatic test_jcond();
    rom[8'h40] = mk(2'd3, 2'd0, 8'h00, 1'b0, 1'b0);
    rom[8'h21] = mk(2'd3, 2'd0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int pol = 0; pol < 2; pol++) begin
        logic [3:0] fl;
        logic [7:0] exp_a;
        fl = 4'b0001 << k;
        if (pol == 1) fl = ~fl;
        exp_a = (pol == 0) ? 8'h40 : 8'h21;
        rom[8'h20] = mk(2'd2, 2'(k), 8'h40, 1'b0, 1'b0);
        run_prog(8'h20, 16'($urandom), 1'b1, fl, 1'b0, 16'h0, 1'b0);
        checks++;
        if (bus.uAddr !== exp_a) begin
          failures++;
          $display("FAIL jcond sel=%0d flags=%b got uAddr=%02h exp=%02h", k, fl, bus.uAddr, exp_a);
        end
      end
    end
  endtask

  task automatic test_wrap();
    rom[8'hFF] = mk(2'd0, 2'd0, 8'h00, 1'b1, 1'b1);
    rom[8'h00] = mk(2'd3, 2'd0, 8'h00, 1'b0, 1'b0);
    run_prog(8'hFF, 16'($urandom), 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.uAddr !== 8'h00) begin
      failures++;
      $display("FAIL wrap got uAddr=%02h exp=00", bus.uAddr);
    end
  endtask

  task automatic test_step_limit();
    rom[8'h30] = mk(2'd1, 2'd0, 8'h30, 1'b1, 1'b0);
    rom[8'h31] = mk(2'd3, 2'd0, 8'h00, 1'b0, 1'b0);
    run_prog(8'h30, 16'($urandom), 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL step_limit_err got=%b exp=1", bus.err);
    end
    run_prog(8'h31, 16'($urandom), 1'b0, 4'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b exp=0", bus.err);
    end
  endtask

  task automatic test_busy_start();
    rom[8'h50] = mk(2'd0, 2'd0, 8'h00, 1'b0, 1'b1);
    rom[8'h51] = mk(2'd3, 2'd0, 8'h00, 1'b1, 1'b1);
    run_prog(8'h50, 16'hA5C3, 1'b0, 4'h0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (bus.uAddr !== 8'h51) begin
      failures++;
      $display("FAIL busy_start_upc got uAddr=%02h exp=51", bus.uAddr);
    end
  endtask

  task automatic test_reset_mid();
    rom[8'h60] = mk(2'd1, 2'd0, 8'h60, 1'b1, 1'b1);
    bus.start = 1'b1; bus.startAddr = 8'h60; bus.operand = 16'h5A5A;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1; bus.start = 1'b1; bus.startAddr = 8'h77;
    tick();
    m_result = 16'h0; m_err = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.result, bus.uAddr, bus.aluI, bus.aAddr, bus.bAddr,
         bus.cN, bus.dOut, bus.yOeBar} !==
        {1'b0, 1'b0, 1'b0, 16'h0, 8'h00, NOP, 4'h0, 4'h0, 1'b0, 16'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b result=%04h uAddr=%02h aluI=%03h oe=%b",
               bus.busy, bus.done, bus.result, bus.uAddr, bus.aluI, bus.yOeBar);
    end
    tick();
    reset = 1'b0; bus.start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({bus.busy, bus.done, bus.uAddr} !== {1'b0, 1'b0, 8'h00}) begin
        failures++;
        $display("FAIL reset_quiet cyc=%0d got busy=%b done=%b uAddr=%02h", c, bus.busy, bus.done, bus.uAddr);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 256; k++) rom[k] = $urandom;
      run_prog(8'($urandom), 16'($urandom), 1'b0, 4'h0, 1'b0, 16'h0, bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.startAddr = 8'h00; bus.operand = 16'h0;
    bus.y = 16'h0; bus.fEq0 = 1'b0; bus.f3 = 1'b0; bus.ovf = 1'b0; bus.cNplus4 = 1'b0;
    for (int k = 0; k < 256; k++) rom[k] = 32'h0;
    m_result = 16'h0;
    m_err    = 1'b0;
    test_reset();
    test_cont_halt();
    test_jcond();
    test_wrap();
    test_step_limit();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
